// File: rtl/mdu_if.sv
// Handshake and result bundle between the control unit and mdu_sequencer.
// The control unit drives the master side; the sequencer implements the slave side.
`timescale 1ns/1ps

interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             done;
  logic             busy;
  logic             stall;
  logic             div_by_zero;
  logic             unsupported;

  modport master (
    output start, alu_sel, op_a, op_b,
    input  result, result_hi, done, busy, stall, div_by_zero, unsupported
  );

  modport slave (
    input  start, alu_sel, op_a, op_b,
    output result, result_hi, done, busy, stall, div_by_zero, unsupported
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Execute sequencer: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide. The divider is built only when MDU_DIV_EN is defined.
`timescale 1ns/1ps

module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
`ifdef MDU_DIV_EN
    S_DIV_RUN = 2'd2,
`endif
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared by both iterative ops: {partial product, remaining multiplier} for
  // MUL, {partial remainder, dividend/quotient bits} for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               dbz_q, dbz_d;
  logic               unsup_q, unsup_d;

  logic               accept;
  logic               busy;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign accept    = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // The multiplier bit consumed each step is the LSB of the accumulator; the
  // carry out of the upper-half add shifts back in at the top.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Bit WIDTH of the difference is the borrow: set means restore.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign busy = (state_q == S_MUL_RUN) || (state_q == S_DIV_RUN);
`else
  assign busy = (state_q == S_MUL_RUN);
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    dbz_d       = dbz_q;
    unsup_d     = unsup_q;

    unique case (state_q)
      S_MUL_RUN: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d     = S_DONE;
          result_d    = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[2*WIDTH-1:WIDTH];
        end
      end
`ifdef MDU_DIV_EN
      S_DIV_RUN: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d     = S_DONE;
          result_d    = div_next[WIDTH-1:0];
          result_hi_d = div_next[2*WIDTH-1:WIDTH];
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // A start in DONE overrides the return to IDLE: zero bubble cycles.
    if (accept) begin
      dbz_d       = 1'b0;
      unsup_d     = 1'b0;
      cnt_d       = '0;
      state_d     = S_DONE;
      result_hi_d = '0;
      case (bus.alu_sel)
        OP_SUB: result_d = bus.op_a - bus.op_b;
        OP_AND: result_d = bus.op_a & bus.op_b;
        OP_OR:  result_d = bus.op_a | bus.op_b;
        OP_MUL: begin
          result_hi_d = result_hi_q;
          acc_d       = {{WIDTH{1'b0}}, bus.op_b};
          opnd_d      = bus.op_a;
          state_d     = S_MUL_RUN;
        end
        OP_DIV: begin
`ifdef MDU_DIV_EN
          if (bus.op_b == '0) begin
            result_d    = '1;
            result_hi_d = bus.op_a;
            dbz_d       = 1'b1;
          end else begin
            result_hi_d = result_hi_q;
            acc_d       = {{WIDTH{1'b0}}, bus.op_a};
            opnd_d      = bus.op_b;
            state_d     = S_DIV_RUN;
          end
`else
          result_d = '0;
          unsup_d  = 1'b1;
`endif
        end
        default: result_d = bus.op_a + bus.op_b;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      dbz_q       <= 1'b0;
      unsup_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      dbz_q       <= dbz_d;
      unsup_q     <= unsup_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.busy        = busy;
  assign bus.stall       = accept || busy;
  assign bus.div_by_zero = dbz_q;
  assign bus.unsupported = unsup_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer (WIDTH = 32): directed vector table,
// multi-cycle corner sequences, and randomized ops against an arithmetic model.
`timescale 1ns/1ps

module tb_mdu_sequencer;
  localparam int W = 32;
  localparam int LAT_MC = W + 1;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, MUL = 4'b0010,
                         DIV = 4'b0011, AND = 4'b0100, OR  = 4'b0101;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        dz;
    logic        un;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  mdu_if #(.WIDTH(W)) bus ();
  mdu_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference model straight from the operation definitions.
  function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] h,
                                output logic dz, output logic un, output int lat);
    logic [63:0] p;
    r = '0; h = '0; dz = 1'b0; un = 1'b0; lat = 1;
    case (sel)
      SUB: r = a - b;
      AND: r = a & b;
      OR:  r = a | b;
      MUL: begin
        p = 64'(a) * 64'(b);
        r = p[31:0]; h = p[63:32]; lat = LAT_MC;
      end
      DIV: begin
        if (!DIV_EN)      un = 1'b1;
        else if (b == 0)  begin r = '1; h = a; dz = 1'b1; end
        else              begin r = a / b; h = a % b; lat = LAT_MC; end
      end
      default: r = a + b;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [31:0] hi,
                              input logic dz, input logic un, input int lat);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.res = res; v.hi = hi; v.dz = dz; v.un = un; v.lat = lat;
    return v;
  endfunction

  // Called at a sample point; returns at cycle 1 of the op (start dropped).
  task automatic launch(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
    bus.start = 1'b1; bus.alu_sel = sel; bus.op_a = a; bus.op_b = b;
    #1;
    check({nm, ":stall_c0"}, bus.stall, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
  endtask

  // Waits (bounded) for done; stops in the done cycle if it arrives.
  task automatic wait_done(input string nm, input int cyc0, input int lat);
    int cyc = cyc0;
    int busy_n = 0;
    int stall_bad = 0;
    while (bus.done !== 1'b1 && cyc < lat + 4) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.stall !== bus.busy) stall_bad++;
      @(posedge clk); #2;
      cyc++;
    end
    check({nm, ":done_cycle"}, cyc, lat);
    check({nm, ":busy_cycles"}, busy_n, lat - cyc0);
    check({nm, ":stall_eq_busy"}, stall_bad, 0);
  endtask

  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [31:0] hi,
                        input logic dz, input logic un, input int lat,
                        input string nm, input bit chain);
    launch(sel, a, b, nm);
    wait_done(nm, 1, lat);
    check({nm, ":result"}, bus.result, res);
    check({nm, ":result_hi"}, bus.result_hi, hi);
    check({nm, ":div_by_zero"}, bus.div_by_zero, dz);
    check({nm, ":unsupported"}, bus.unsupported, un);
    check({nm, ":stall_done"}, {bus.stall, bus.busy}, 2'b00);
    if (!chain) begin
      @(posedge clk); #2;
      check({nm, ":done_pulse"}, bus.done, 0);
      check({nm, ":hold"}, {bus.result_hi, bus.result}, {hi, res});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [3:0]  sel_long;
    logic [31:0] exp_lo, exp_hi;
    logic [31:0] mr, mh;
    logic        mdz, mun;
    int          mlat;
    logic [3:0]  rsel;
    logic [31:0] ra, rb;
    int          r;

    vecs[0]  = mk(ADD,   32'd7,          32'd5,          32'd12,         32'd0, 0, 0, 1);
    vecs[1]  = mk(SUB,   32'd3,          32'd5,          32'hFFFF_FFFE,  32'd0, 0, 0, 1);
    vecs[2]  = mk(AND,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  32'd0, 0, 0, 1);
    vecs[3]  = mk(OR,    32'h0F0F_0000,  32'h0000_00FF,  32'h0F0F_00FF,  32'd0, 0, 0, 1);
    vecs[4]  = mk(4'hF,  32'd10,         32'd20,         32'd30,         32'd0, 0, 0, 1);
    vecs[5]  = mk(ADD,   32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 0, 0, 1);
    vecs[6]  = mk(MUL,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1, 0, 0, LAT_MC);
`ifdef MDU_DIV_EN
    vecs[7]  = mk(DIV,   32'd100,        32'd7,          32'd14,         32'd2, 0, 0, LAT_MC);
    vecs[8]  = mk(DIV,   32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 1, 0, 1);
    vecs[11] = mk(DIV,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0, 0, 0, LAT_MC);
`else
    vecs[7]  = mk(DIV,   32'd100,        32'd7,          32'd0,          32'd0, 0, 1, 1);
    vecs[8]  = mk(DIV,   32'd9,          32'd0,          32'd0,          32'd0, 0, 1, 1);
    vecs[11] = mk(DIV,   32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 0, 1, 1);
`endif
    vecs[9]  = mk(ADD,   32'd2,          32'd3,          32'd5,          32'd0, 0, 0, 1);
    vecs[10] = mk(MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE, 0, 0, LAT_MC);

    rst = 1'b1;
    bus.start = 1'b0; bus.alu_sel = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset:result", bus.result, 0);
    check("reset:result_hi", bus.result_hi, 0);
    check("reset:ctrl", {bus.done, bus.busy, bus.stall, bus.div_by_zero, bus.unsupported}, 0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi,
             vecs[i].dz, vecs[i].un, vecs[i].lat, $sformatf("vec%0d", i), 1'b0);

    // Start while a multi-cycle op runs is ignored; then back-to-back start in done.
    sel_long = DIV_EN ? DIV : MUL;
    exp_lo   = DIV_EN ? 32'd14 : 32'd700;
    exp_hi   = DIV_EN ? 32'd2  : 32'd0;
    launch(sel_long, 32'd100, 32'd7, "busy_ign");
    repeat (4) begin @(posedge clk); #2; end
    bus.start = 1'b1; bus.alu_sel = SUB; bus.op_a = 32'd3; bus.op_b = 32'd5;
    #1;
    check("busy_ign:stall_c5", bus.stall, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
    check("busy_ign:still_busy", {bus.busy, bus.done}, 2'b10);
    wait_done("busy_ign", 6, LAT_MC);
    check("busy_ign:result", {bus.result_hi, bus.result}, {exp_hi, exp_lo});
    run_op(SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 0, 0, 1, "b2b", 1'b0);

    // Reset at cycle 10 of a MUL aborts it without a done pulse.
    launch(MUL, 32'hFFFF_FFFF, 32'd2, "rst_mid");
    repeat (9) begin @(posedge clk); #2; end
    check("rst_mid:c10_busy", {bus.busy, bus.done}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid:c11_ctrl", {bus.done, bus.busy, bus.stall}, 3'b000);
    check("rst_mid:c11_result", {bus.result_hi, bus.result}, 64'd0);
    run_op(ADD, 32'd1, 32'd1, 32'd2, 32'd0, 0, 0, 1, "rst_add", 1'b0);

    // Randomized ops, some chained back-to-back.
    for (int i = 0; i < 40; i++) begin
      r    = int'($urandom_range(0, 9));
      rsel = (r < 6) ? 4'(r) : 4'($urandom_range(6, 15));
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      model(rsel, ra, rb, mr, mh, mdz, mun, mlat);
      run_op(rsel, ra, rb, mr, mh, mdz, mun, mlat, $sformatf("rnd%0d", i), (i % 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle execute sequencer that sits between the control unit's decoded `ALU_Selection` and the register-file write-back. It runs single-cycle logic and arithmetic ops directly, and sequences iterative unsigned multiply (shift-add) and divide (restoring) over `WIDTH` cycles. It asserts `stall` so the PC logic selects hold until the result is ready, then pulses `done`.

## Interface
- `WIDTH`, default 32: operand and result width; must be a power of two, at least 4.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to execute `alu_sel` on `op_a`/`op_b`.
- `alu_sel`  in  4  operation select, using the control-unit codes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR.
  - All other codes are treated as ADD.
- `op_a`  in  WIDTH  operand A (dividend for DIV).
- `op_b`  in  WIDTH  operand B (divisor for DIV).
- `result`  out  WIDTH  low product, quotient, or single-cycle result.
- `result_hi`  out  WIDTH  high product, remainder, or 0.
- `done`  out  1  one-cycle pulse; `result`/`result_hi` valid.
- `busy`  out  1  high while in MUL_RUN or DIV_RUN.
- `stall`  out  1  combinational; PC-hold request.
- `div_by_zero`  out  1  registered flag; valid with `done`.
- `unsupported`  out  1  registered flag; valid with `done`.

## Operation
- **States:** IDLE, MUL_RUN, DIV_RUN, DONE. Reset state is IDLE.
- **Reset values:** all registered outputs are 0, the iteration counter is 0, and the state is IDLE.
- **Start acceptance:** `start` is accepted only in IDLE or DONE. It is ignored in MUL_RUN or DIV_RUN, with no effect on state or outputs.
- **Single-cycle ops** (ADD, SUB, AND, OR, unknown codes):
  - Go to DONE.
  - `result` = op result modulo 2^WIDTH; SUB wraps.
  - `result_hi` = 0.
- **MUL:**
  - Latch operands, clear the 2·WIDTH accumulator and counter, then go to MUL_RUN.
  - Each cycle: if multiplier bit 0 is set, add the multiplicand into the upper half; then shift right by 1.
  - After WIDTH iterations (counter = WIDTH−1), go to DONE.
  - `result` = product[WIDTH−1:0], `result_hi` = product[2·WIDTH−1:WIDTH].
- **DIV with `op_b` ≠ 0:**
  - Go to DIV_RUN and run restoring division, one quotient bit per cycle, MSB first.
  - After WIDTH iterations, go to DONE.
  - `result` = quotient, `result_hi` = remainder.
- **DIV with `op_b` = 0:**
  - Go directly to DONE.
  - `result` = all ones, `result_hi` = `op_a`, `div_by_zero` = 1.
- **DONE:**
  - `done` = 1 for exactly this cycle.
  - Outputs hold their values until the next accepted start.
  - The next state is IDLE, or the new op's state if `start` is high.
- **Flag clearing:** `div_by_zero` and `unsupported` clear on every accepted start.
- **Stall:** `stall` = (`start` accepted this cycle) OR `busy`. It is low in the `done` cycle, so the PC advances on the edge that ends it.
- **Reset priority:** `rst` overrides `start` and every state. Reset mid-run aborts without a `done` pulse.

## Timing
- **Reference point:** cycle 0 is the cycle in which `start` is sampled high in IDLE or DONE.
- **Single-cycle ops and DIV by zero:** `done` at cycle 1; `stall` high at cycle 0 only.
- **MUL and DIV:**
  - `busy` high for cycles 1..WIDTH.
  - `done` at cycle WIDTH+1; `stall` high for cycles 0..WIDTH.
- **Back-to-back:** a start in the `done` cycle is cycle 0 of the next op. Zero bubble cycles.
- **Reset:** `rst` high at cycle N gives IDLE with cleared outputs at cycle N+1, and `start` is accepted at N+1.

## Configuration
- **Macro:** `MDU_DIV_EN`.
- **Defined:** DIV_RUN and the restoring-divide datapath are built as described; `unsupported` is always 0.
- **Undefined:**
  - No divider logic and no DIV_RUN state.
  - DIV is handled as a single-cycle op: `result` = 0, `result_hi` = 0, `div_by_zero` = 0, `unsupported` = 1, `done` at cycle 1.

## Test plan
All scenarios use WIDTH = 32.

- **ADD, single cycle:** ADD 7 + 5 → `done` at cycle 1, `result` = 12, `result_hi` = 0, `stall` high at cycle 0 only.
- **MUL, full product:** MUL 0xFFFFFFFF × 2 → `busy` for cycles 1..32, `done` at cycle 33, `result` = 0xFFFFFFFE, `result_hi` = 1.
- **DIV, normal:** DIV 100 / 7 → `done` at cycle 33, `result` = 14, `result_hi` = 2. Repeat with `MDU_DIV_EN` undefined → `done` at cycle 1, `unsupported` = 1, results 0.
- **DIV by zero:** DIV 9 / 0 → `done` at cycle 1, `result` = 0xFFFFFFFF, `result_hi` = 9, `div_by_zero` = 1. Next ADD clears the flag.
- **Reset mid-run:** `rst` at cycle 10 of a MUL → cycle 11 in IDLE, all outputs 0, no `done`. ADD 1 + 1 started at cycle 11 gives `done` at cycle 12, `result` = 2.
- **Start while busy, then back-to-back:** `start` SUB 3 − 5 at cycle 5 of a DIV is ignored. Then SUB 3 − 5 issued in that DIV's `done` cycle → `done` on the next cycle, `result` = 0xFFFFFFFE.
